// File: rtl/flt_add_seq.sv
// flt_add_seq: multi-cycle floating-point add/sub with start/ack handshake.
// Ports: clk, reset (sync, high), start, a, b -> result, ack, busy. Macro: FLT_ROUND_EN.
module flt_add_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ack,
  output logic                   busy
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int DW = MAN_W + 5;
  localparam int EW = EXP_W + 1;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EW-1:0]    ONE  = EW'(1);
  localparam logic [EW-1:0]    TWO  = EW'(2);
  localparam logic [EW-1:0]    FLSH = EW'(MAN_W + 3);
  localparam logic [EW-1:0]    ETOP = {1'b0, EMAX};
  localparam logic [W-1:0]     QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD,
    S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          sx_q, sx_d, sub_q, sub_d;
  logic [EW-1:0] ex_q, ex_d, ey_q, ey_d;
  logic [DW-1:0] mx_q, mx_d, my_q, my_d;
  logic          spec_q, spec_d;
  logic [W-1:0]  spv_q, spv_d;
  logic [W-1:0]  res_q, res_d;
  logic          ack_q, ack_d;

  logic            swap, a_inf, b_inf;
  logic [W-1:0]    xop, yop;
  logic [EW-1:0]   ex_u, ey_u, dexp, ey_inc;
  logic [DW-1:0]   sum;
  logic [MAN_W+1:0] rnd;
  logic            inc;

  // On equal magnitude A stays X, so A wins ties.
  assign swap  = b_q[W-2:0] > a_q[W-2:0];
  assign xop   = swap ? b_q : a_q;
  assign yop   = swap ? a_q : b_q;
  assign a_inf = a_q[W-2:MAN_W] == EMAX;
  assign b_inf = b_q[W-2:MAN_W] == EMAX;

  // Subnormals share the exponent of the smallest normal.
  assign ex_u = (xop[W-2:MAN_W] == '0) ? ONE
              : {1'b0, xop[W-2:MAN_W]};
  assign ey_u = (yop[W-2:MAN_W] == '0) ? ONE
              : {1'b0, yop[W-2:MAN_W]};
  assign dexp   = ex_q - ey_q;
  assign ey_inc = ey_q + ONE;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sx_d    = sx_q;
    sub_d   = sub_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    mx_d    = mx_q;
    my_d    = my_q;
    spec_d  = spec_q;
    spv_d   = spv_q;
    res_d   = res_q;
    ack_d   = ack_q;
    sum     = '0;
    rnd     = '0;
    inc     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ack_d   = 1'b0;
          spec_d  = 1'b0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sx_d  = xop[W-1];
        sub_d = a_q[W-1] ^ b_q[W-1];
        ex_d  = ex_u;
        ey_d  = ey_u;
        mx_d  = {1'b0, |xop[W-2:MAN_W],
                 xop[MAN_W-1:0], 3'b000};
        my_d  = {1'b0, |yop[W-2:MAN_W],
                 yop[MAN_W-1:0], 3'b000};
        if (a_inf && b_inf) begin
          spec_d  = 1'b1;
          spv_d   = (a_q[W-1] != b_q[W-1]) ? QNAN : a_q;
          state_d = S_PACK;
        end else if (a_inf) begin
          spec_d  = 1'b1;
          spv_d   = a_q;
          state_d = S_PACK;
        end else if (b_inf) begin
          spec_d  = 1'b1;
          spv_d   = b_q;
          state_d = S_PACK;
        end else if (ex_u == ey_u) begin
          state_d = S_ADD;
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // Far-away Y only matters as a sticky bit.
        if (dexp > FLSH) begin
          my_d    = {{(DW-1){1'b0}}, |my_q};
          ey_d    = ex_q;
          state_d = S_ADD;
        end else begin
          my_d = {1'b0, my_q[DW-1:2], |my_q[1:0]};
          ey_d = ey_inc;
          if (ey_inc == ex_q) state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum  = sub_q ? (mx_q - my_q) : (mx_q + my_q);
        mx_d = sum;
        if (sum[DW-1])
          state_d = S_NORM;
        else if (sum == '0)
          state_d = S_ROUND;
        else if (!sum[DW-2] && ex_q > ONE)
          state_d = S_NORM;
        else
          state_d = S_ROUND;
      end
      S_NORM: begin
        if (mx_q[DW-1]) begin
          mx_d    = {1'b0, mx_q[DW-1:2], |mx_q[1:0]};
          ex_d    = ex_q + ONE;
          state_d = S_ROUND;
        end else begin
          mx_d = {mx_q[DW-2:0], 1'b0};
          ex_d = ex_q - ONE;
          // Stop once normalised or at the subnormal floor.
          if (mx_q[DW-3] || ex_q == TWO) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
`ifdef FLT_ROUND_EN
        inc = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
`else
        inc = 1'b0;
`endif
        rnd = mx_q[DW-1:3] + {{(MAN_W+1){1'b0}}, inc};
        if (rnd[MAN_W+1]) begin
          mx_d = {1'b0, rnd[MAN_W+1:1], 3'b000};
          ex_d = ex_q + ONE;
        end else begin
          mx_d = {rnd, 3'b000};
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        if (spec_q)
          res_d = spv_q;
        else if (mx_q[DW-1:3] == '0)
          res_d = '0;
        else if (ex_q >= ETOP)
          res_d = {sx_q, EMAX, {MAN_W{1'b0}}};
        else if (mx_q[DW-2])
          res_d = {sx_q, ex_q[EXP_W-1:0], mx_q[DW-3:3]};
        else
          res_d = {sx_q, {EXP_W{1'b0}}, mx_q[DW-3:3]};
        ack_d   = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sx_q    <= 1'b0;
      sub_q   <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      spec_q  <= 1'b0;
      spv_q   <= '0;
      res_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sx_q    <= sx_d;
      sub_q   <= sub_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      spec_q  <= spec_d;
      spv_q   <= spv_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
    end
  end

  assign result = res_q;
  assign ack    = ack_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
